// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-detector frame-scan feeder.
package edge_pkg;

  // Scan controller states. These describe the address side of the pipeline.
  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFetch,
    StStream,
    StGap,
    StWait,
    StFin
  } state_e;

  localparam int unsigned PIX_W_DEF = 8;

  // Minimum address width needed to index an n x n frame.
  function automatic int unsigned frame_addr_bits(input int unsigned n);
    int unsigned cells;
    cells = n * n;
    return (cells <= 2) ? 1 : $clog2(cells);
  endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Row-major and column-major address generator for a square frame.
// lr walks r*IMG_N + c linearly; ud accumulates IMG_N per pixel and reloads
// to (line + 1) at each line wrap, so no multiplier is needed.
module scan_addr_gen #(
  parameter int unsigned IMG_N  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_lr_addr,
  output logic [ADDR_W-1:0] o_ud_addr,
  output logic              o_line_first,
  output logic              o_line_last,
  output logic              o_frame_last
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(IMG_N - 1);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(IMG_N);
  localparam logic [ADDR_W-1:0] One      = ADDR_W'(1);

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_lr;
  logic [ADDR_W-1:0] r_ud;

  logic w_line_first;
  logic w_line_last;
  logic w_frame_last;

  // Position flags for the pixel currently addressed.
  always_comb begin
    w_line_first = (r_col == '0);
    w_line_last  = (r_col == LastIdx);
    w_frame_last = w_line_last && (r_row == LastIdx);
  end

  // Counter update: step within a line, wrap to the next line, or rewind after the frame.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_lr  <= '0;
      r_ud  <= '0;
    end else if (i_adv) begin
      if (w_frame_last) begin
        r_row <= '0;
        r_col <= '0;
        r_lr  <= '0;
        r_ud  <= '0;
      end else if (w_line_last) begin
        r_row <= r_row + One;
        r_col <= '0;
        r_lr  <= r_lr + One;
        r_ud  <= r_row + One;
      end else begin
        r_col <= r_col + One;
        r_lr  <= r_lr + One;
        r_ud  <= r_ud + LineStep;
      end
    end
  end

  assign o_lr_addr    = r_lr;
  assign o_ud_addr    = r_ud;
  assign o_line_first = w_line_first;
  assign o_line_last  = w_line_last;
  assign o_frame_last = w_frame_last;

endmodule

// File: rtl/edge_scan_feeder.sv
// Frame-scan initiator for the two-direction edge detector. Streams a square
// frame row-major on the left-right lane and column-major on the up-down lane.
// The FSM runs on the address side; a two-stage control pipeline (RAM read
// latency + output register) aligns enb, modes and clear pulses with the data.
module edge_scan_feeder
  import edge_pkg::*;
#(
  parameter int unsigned IMG_N   = 64,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] lr_addr,
  input  logic [PIX_W-1:0]  lr_rdata,
  output logic [ADDR_W-1:0] ud_addr,
  input  logic [PIX_W-1:0]  ud_rdata,
  output logic [PIX_W-1:0]  leftRightArray,
  output logic [PIX_W-1:0]  upDownArray,
  output logic              enb,
  output logic              resetBuff,
  output logic              buffLRMode,
  output logic              buffUDMode,
  output logic              det_reset,
  input  logic              complete,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  // Wait counter runs 0..TIMEOUT-1, giving exactly TIMEOUT WAIT cycles.
  localparam int unsigned   WaitW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);

  if (ADDR_W < frame_addr_bits(IMG_N)) begin : g_addr_w_chk
    $error("edge_scan_feeder: ADDR_W too small for IMG_N*IMG_N");
  end
  if (IMG_N < 2) begin : g_img_n_chk
    $error("edge_scan_feeder: IMG_N must be at least 2");
  end

  state_e r_state;
  state_e w_state_d;

  logic w_clr;
  logic w_adv;
  logic w_tmo_set;

  logic w_line_first;
  logic w_line_last;
  logic w_frame_last;

  logic [WaitW-1:0] r_wait;
  logic             r_timeout;

  // Stage 1: control for addresses the RAM is reading this cycle.
  logic r_s1_vld;
  logic r_s1_first;
  logic r_s1_rb;
  logic r_s1_dr;

  // Stage 2: registered detector-facing outputs.
  logic             r_enb;
  logic             r_mode;
  logic             r_resetbuff;
  logic             r_det_reset;
  logic [PIX_W-1:0] r_lr_pix;
  logic [PIX_W-1:0] r_ud_pix;

  scan_addr_gen #(
    .IMG_N  (IMG_N),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_clr),
    .i_adv        (w_adv),
    .o_lr_addr    (lr_addr),
    .o_ud_addr    (ud_addr),
    .o_line_first (w_line_first),
    .o_line_last  (w_line_last),
    .o_frame_last (w_frame_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic and address-side strobes.
  always_comb begin
    w_state_d = r_state;
    w_clr     = 1'b0;
    w_adv     = 1'b0;
    w_tmo_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StClr;
        end
      end
      StClr: begin
        w_clr     = 1'b1;
        w_state_d = StFetch;
      end
      StFetch: begin
        w_adv     = 1'b1;
        w_state_d = StStream;
      end
      StStream: begin
        w_adv = 1'b1;
        if (w_frame_last) begin
          w_state_d = StWait;
        end else if (w_line_last) begin
          w_state_d = StGap;
        end
      end
      StGap: begin
        w_state_d = StFetch;
      end
      StWait: begin
        if (complete) begin
          w_state_d = StFin;
        end else if (r_wait == WaitLast) begin
          w_tmo_set = 1'b1;
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Cycles spent in WAIT; held at zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset || (r_state != StWait)) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + WaitOne;
    end
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if ((r_state == StIdle) && start) begin
      r_timeout <= 1'b0;
    end else if (w_tmo_set) begin
      r_timeout <= 1'b1;
    end
  end

  // Two-stage control/data pipeline matching the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_rb     <= 1'b0;
      r_s1_dr     <= 1'b0;
      r_enb       <= 1'b0;
      r_mode      <= 1'b0;
      r_resetbuff <= 1'b0;
      r_det_reset <= 1'b0;
      r_lr_pix    <= '0;
      r_ud_pix    <= '0;
    end else begin
      r_s1_vld    <= w_adv;
      r_s1_first  <= w_line_first;
      r_s1_rb     <= (r_state == StClr) || (r_state == StGap);
      r_s1_dr     <= (r_state == StClr);
      r_enb       <= r_s1_vld;
      r_mode      <= r_s1_vld && !r_s1_first;
      r_resetbuff <= r_s1_rb;
      r_det_reset <= r_s1_dr;
      // Data holds its last value outside valid cycles.
      if (r_s1_vld) begin
        r_lr_pix <= lr_rdata;
        r_ud_pix <= ud_rdata;
      end
    end
  end

  assign leftRightArray = r_lr_pix;
  assign upDownArray    = r_ud_pix;
  assign enb            = r_enb;
  assign resetBuff      = r_resetbuff;
  assign buffLRMode     = r_mode;
  assign buffUDMode     = r_mode;
  assign det_reset      = r_det_reset;
  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StFin) && !r_timeout;
  assign timeout_err    = r_timeout;

endmodule

// File: tb/tb_edge_scan_feeder.sv
// Directed bench for edge_scan_feeder on a 4x4 frame with RAM[i] = i.
module tb_edge_scan_feeder;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 12;
  localparam int unsigned PW  = 8;
  localparam int unsigned TMO = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          complete;
  logic [AW-1:0] lr_addr;
  logic [AW-1:0] ud_addr;
  logic [PW-1:0] lr_rdata;
  logic [PW-1:0] ud_rdata;
  logic [PW-1:0] lr_pix;
  logic [PW-1:0] ud_pix;
  logic          enb;
  logic          rb;
  logic          lrm;
  logic          udm;
  logic          dr;
  logic          busy;
  logic          done;
  logic          tmo;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard of expected pixels, pushed when a frame is started.
  int q_lr[$];
  int q_ud[$];
  bit q_md[$];

  int f_enb;
  int f_rb;
  int f_dr;
  int f_done;
  bit pend_gap;
  int last_lr;
  int k;

  always #5 clk = ~clk;

  // Synchronous-read frame RAM, two ports, contents RAM[i] = i.
  always_ff @(posedge clk) begin
    lr_rdata <= lr_addr[PW-1:0];
    ud_rdata <= ud_addr[PW-1:0];
  end

  edge_scan_feeder #(
    .IMG_N   (N),
    .ADDR_W  (AW),
    .PIX_W   (PW),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .lr_addr        (lr_addr),
    .lr_rdata       (lr_rdata),
    .ud_addr        (ud_addr),
    .ud_rdata       (ud_rdata),
    .leftRightArray (lr_pix),
    .upDownArray    (ud_pix),
    .enb            (enb),
    .resetBuff      (rb),
    .buffLRMode     (lrm),
    .buffUDMode     (udm),
    .det_reset      (dr),
    .complete       (complete),
    .busy           (busy),
    .done           (done),
    .timeout_err    (tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({lr_addr, ud_addr, lr_pix, ud_pix, enb, rb, lrm, udm, dr, busy, done, tmo});
  endfunction

  task automatic push_frame();
    for (int j = 0; j < int'(N); j++) begin
      for (int p = 0; p < int'(N); p++) begin
        q_lr.push_back(j * int'(N) + p);
        q_ud.push_back(p * int'(N) + j);
        q_md.push_back(p != 0);
      end
    end
  endtask

  task automatic begin_frame();
    f_enb  = 0;
    f_rb   = 0;
    f_dr   = 0;
    f_done = 0;
    push_frame();
  endtask

  // Observe one cycle of DUT outputs and score any emitted pixel.
  task automatic sample();
    int e_lr;
    int e_ud;
    bit e_md;
    if (pend_gap) begin
      chk("gap_after_line", 64'({enb, rb}), 64'(2'b01));
      pend_gap = 1'b0;
    end
    if (rb) chk("rb_without_enb", 64'(enb), 64'(0));
    f_enb  += int'(enb);
    f_rb   += int'(rb);
    f_dr   += int'(dr);
    f_done += int'(done);
    if (enb) begin
      if (q_lr.size() == 0) begin
        chk("enb_unexpected", 64'(enb), 64'(0));
      end else begin
        e_lr = q_lr.pop_front();
        e_ud = q_ud.pop_front();
        e_md = q_md.pop_front();
        chk("lr_pix", 64'(lr_pix), 64'(e_lr));
        chk("ud_pix", 64'(ud_pix), 64'(e_ud));
        chk("lr_mode", 64'(lrm), 64'(e_md));
        chk("ud_mode", 64'(udm), 64'(e_md));
        last_lr = e_lr;
        if ((e_lr % int'(N)) == int'(N) - 1 && e_lr != int'(N * N) - 1) pend_gap = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q_lr.size() != 0; i++) cyc();
    chk("drain_timeout", 64'(q_lr.size()), 64'(0));
  endtask

  task automatic frame_counts(input string tag, input int exp_done);
    chk({tag, "_enb_count"}, 64'(f_enb), 64'(N * N));
    chk({tag, "_rb_count"}, 64'(f_rb), 64'(N));
    chk({tag, "_det_reset_count"}, 64'(f_dr), 64'(1));
    chk({tag, "_done_count"}, 64'(f_done), 64'(exp_done));
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    complete = 1'b0;
    pend_gap = 1'b0;
    last_lr  = -1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("reset_state", all_outs(), 64'(0));

    // Frame 1: normal completion, complete raised 5 cycles into WAIT.
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    cyc();
    chk("fetch_addrs", 64'({lr_addr, ud_addr}), 64'({12'd0, 12'd0}));
    chk("fetch_no_enb", 64'(enb), 64'(0));
    cyc();
    chk("second_addrs", 64'({lr_addr, ud_addr}), 64'({12'd1, 12'd4}));
    chk("clr_pulses", 64'({dr, rb}), 64'(2'b11));
    cyc();
    chk("first_enb_latency", 64'(enb), 64'(1));
    drain();
    // Last pixel shows in WAIT cycle 2; advance to WAIT cycle 5.
    repeat (3) cyc();
    chk("no_done_before_complete", 64'(f_done), 64'(0));
    complete = 1'b1;
    cyc();
    complete = 1'b0;
    chk("done_pulse", 64'({done, busy}), 64'(2'b11));
    cyc();
    chk("after_done", 64'({done, busy, tmo}), 64'(0));
    frame_counts("f1", 1);

    // Frame 2: complete never arrives, expect timeout after TMO WAIT cycles.
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 1;
    while (!tmo && k < 200) begin
      cyc();
      k++;
    end
    chk("timeout_cycle", 64'(k), 64'(N * (N + 1) + 1 + TMO));
    chk("timeout_fin", 64'({done, busy}), 64'(2'b01));
    cyc();
    chk("timeout_idle", 64'({busy, tmo}), 64'(2'b01));
    chk("f2_queue_empty", 64'(q_lr.size()), 64'(0));
    frame_counts("f2", 0);

    // Frame 3: new start clears timeout; extra start mid-frame; reset at pixel 6.
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_clears_timeout", 64'({busy, tmo}), 64'(2'b10));
    for (int i = 0; i < 50 && q_lr.size() > int'(N * N) - 2; i++) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 50 && last_lr != 6; i++) cyc();
    chk("reached_pixel6", 64'(last_lr), 64'(6));
    reset = 1'b1;
    cyc();
    chk("reset_abort", all_outs(), 64'(0));
    chk("f3_no_done", 64'(f_done), 64'(0));
    q_lr.delete();
    q_ud.delete();
    q_md.delete();
    pend_gap = 1'b0;
    reset = 1'b0;
    cyc();
    chk("idle_after_abort", all_outs(), 64'(0));

    // Frame 4: restart from 0 with complete held high; it must not end the stream early.
    complete = 1'b1;
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("restart_addrs", 64'({lr_addr, ud_addr}), 64'({12'd0, 12'd0}));
    drain();
    for (int i = 0; i < 50 && busy; i++) cyc();
    chk("f4_idle", 64'({busy, tmo}), 64'(0));
    complete = 1'b0;
    frame_counts("f4", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
